kws_mac_ctrl: RTL and testbench

CFU-side controller for the KWS MAC datapath: it accepts CPU custom-instruction commands over a valid/ready handshake and decodes `function_id`. It registers operands, drives the combinational `mac` datapath, holds the 32-bit accumulator and a MAC-operation counter, and returns results over a buffered response handshake. It sits directly upstream and around `mac`, between the CPU CFU bus and the datapath.

---
 rtl/kws_mac_ctrl.sv | 169 ++++++++++++++++
 tb/tb_kws_mac_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kws_mac_ctrl.sv
// KWS MAC CFU controller: command decode, operand stage, acc/cnt, response buffer.
// Optional macro KWS_MAC_CTRL_SAT_EN: saturate MAC results to signed 32-bit.

module mac (
   input  logic [2:0]  function_id,
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [31:0] acc,
   output logic [31:0] acc_next
);

   logic signed [9:0]  a;
   logic signed [9:0]  f;
   logic signed [19:0] p;
   logic [31:0]        sum;
   logic               fid_unused;

   assign fid_unused = ^function_id[2:1];

   // flipping the sign bit of an int8 yields (x+128) as unsigned
   always_comb begin
      sum = '0;
      a   = '0;
      f   = '0;
      p   = '0;
      for (int i = 0; i < 4; i++) begin
         a = {2'b00, ~in0[8*i+7], in0[8*i +: 7]};
         f = {{2{in1[8*i+7]}}, in1[8*i +: 8]};
         p = 20'(a) * 20'(f);
         if (i == 0 || !function_id[0])
            sum = sum + 32'(p);
      end
   end

   assign acc_next = acc + sum;

endmodule

module kws_mac_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_function_id,
   input  logic [31:0] cmd_inputs_0,
   input  logic [31:0] cmd_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_outputs_0
);

   typedef enum logic [2:0] {
      OP_MAC4 = 3'd0,
      OP_MAC1 = 3'd1,
      OP_SET  = 3'd2,
      OP_GET  = 3'd3,
      OP_CNT  = 3'd4,
      OP_CLR  = 3'd5
   } op_t;

   logic             s1_v;
   logic [2:0]       s1_f;
   logic [31:0]      s1_in0;
   logic [31:0]      s1_in1;
   logic [31:0]      acc;
   logic [CNT_W-1:0] cnt;

   logic             advance;
   logic             accept;
   logic             fire;
   logic             fid_unused;
   logic [31:0]      acc_next;
   logic [31:0]      mac_res;
   logic [31:0]      acc_d;
   logic [31:0]      rsp_d;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   assign fid_unused = ^cmd_function_id[9:3];

   assign advance   = !rsp_valid || rsp_ready;
   assign cmd_ready = !s1_v || advance;
   assign accept    = cmd_valid && cmd_ready;
   assign fire      = s1_v && advance;

   mac u_mac (
      .function_id (s1_f),
      .in0         (s1_in0),
      .in1         (s1_in1),
      .acc         (acc),
      .acc_next    (acc_next)
   );

`ifdef KWS_MAC_CTRL_SAT_EN
   logic [31:0] delta;
   logic        ovf;

   // product sum is small, so the wrapped delta carries its true sign
   assign delta = acc_next - acc;
   assign ovf   = (acc[31] == delta[31])
               && (acc_next[31] != acc[31]);
   assign mac_res = !ovf ? acc_next :
                    acc[31] ? 32'h8000_0000 :
                              32'h7FFF_FFFF;
`else
   assign mac_res = acc_next;
`endif

   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   always_comb begin
      acc_d = acc;
      cnt_d = cnt;
      rsp_d = '0;
      unique case (s1_f)
         OP_MAC4, OP_MAC1: begin
            acc_d = mac_res;
            cnt_d = cnt_inc;
            rsp_d = mac_res;
         end
         OP_SET: begin
            acc_d = s1_in0;
            rsp_d = acc;
         end
         OP_GET: rsp_d = acc;
         OP_CNT: rsp_d = 32'(cnt);
         OP_CLR: begin
            acc_d = '0;
            cnt_d = '0;
            rsp_d = acc;
         end
         default: rsp_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_v          <= 1'b0;
         s1_f          <= '0;
         s1_in0        <= '0;
         s1_in1        <= '0;
         acc           <= '0;
         cnt           <= '0;
         rsp_valid     <= 1'b0;
         rsp_outputs_0 <= '0;
      end else begin
         if (accept) begin
            s1_f   <= cmd_function_id[2:0];
            s1_in0 <= cmd_inputs_0;
            s1_in1 <= cmd_inputs_1;
         end
         if (accept)
            s1_v <= 1'b1;
         else if (fire)
            s1_v <= 1'b0;
         if (fire) begin
            acc           <= acc_d;
            cnt           <= cnt_d;
            rsp_outputs_0 <= rsp_d;
            rsp_valid     <= 1'b1;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kws_mac_ctrl.sv
// Bench for kws_mac_ctrl: directed steps plus random traffic vs. arithmetic model.
// Honours KWS_MAC_CTRL_SAT_EN for expected MAC results.

module tb_kws_mac_ctrl;

   localparam int CNT_W = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_function_id = '0;
   logic [31:0] cmd_inputs_0 = '0;
   logic [31:0] cmd_inputs_1 = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_outputs_0;

   always #5 clk = ~clk;

   kws_mac_ctrl #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_function_id (cmd_function_id),
      .cmd_inputs_0    (cmd_inputs_0),
      .cmd_inputs_1    (cmd_inputs_1),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_outputs_0   (rsp_outputs_0)
   );

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   cmd_t        pend[$];
   logic [31:0] expq[$];
   logic [31:0] got[$];
   int          total = 0;
   int          bad = 0;
   bit          last_acc;
   bit          last_rv;
   logic [31:0] m_acc = '0;
   int          m_cnt = 0;

   function automatic logic [31:0] model(input cmd_t c);
      logic [31:0] res;
      longint      s;
      longint      r;
      int          x;
      int          w;
      int          n;
      res = '0;
      case (c.f)
         3'd0, 3'd1: begin
            s = 0;
            n = (c.f == 3'd1) ? 1 : 4;
            for (int i = 0; i < n; i++) begin
               x = int'($signed(c.a[8*i +: 8])) + 128;
               w = int'($signed(c.b[8*i +: 8]));
               s = s + longint'(x * w);
            end
            r = longint'($signed(m_acc)) + s;
`ifdef KWS_MAC_CTRL_SAT_EN
            if (r > 64'sd2147483647) r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
            m_acc = r[31:0];
            if (m_cnt < CNT_MAX) m_cnt++;
            res = m_acc;
         end
         3'd2: begin res = m_acc; m_acc = c.a; end
         3'd3: res = m_acc;
         3'd4: res = 32'(m_cnt);
         3'd5: begin res = m_acc; m_acc = '0; m_cnt = 0; end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
      cmd_t c;
      c.f = f;
      c.a = a;
      c.b = b;
      pend.push_back(c);
   endtask

   // one clock: drive at negedge, sample handshakes, advance
   task automatic cycle(input bit rr);
      cmd_t c;
      c = '0;
      if (pend.size() > 0) c = pend[0];
      cmd_valid       = (pend.size() > 0);
      cmd_function_id = {7'($urandom), c.f};
      cmd_inputs_0    = c.a;
      cmd_inputs_1    = c.b;
      rsp_ready       = rr;
      #1;
      last_rv  = rsp_valid;
      last_acc = cmd_valid && cmd_ready;
      if (rsp_valid && rr) begin
         got.push_back(rsp_outputs_0);
         check("rsp_expected", 32'(expq.size() > 0), 32'd1);
         if (expq.size() > 0)
            check("rsp_data", rsp_outputs_0, expq.pop_front());
      end
      if (last_acc) begin
         expq.push_back(model(pend[0]));
         pend.delete(0);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pend.size() > 0 || expq.size() > 0) && n < 100) begin
         cycle(1'b1);
         n++;
      end
      check("drain_left", 32'(pend.size() + expq.size()), 32'd0);
   endtask

   initial begin : main
      logic [7:0]  accb;
      logic [7:0]  rvb;
      logic [31:0] hold;
      int          nacc;
      logic [2:0]  f;
      logic [31:0] a;

      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_out", rsp_outputs_0, 32'd0);
      reset_n = 1'b1;

      // basic MAC4 and counter
      got.delete();
      push(3'd5, 32'd0, 32'd0);
      push(3'd0, 32'h0000_0000, 32'h0101_0101);
      push(3'd4, 32'd0, 32'd0);
      drain();
      check("mac4_basic", got[1], 32'h0000_0200);
      check("cnt_one", got[2], 32'h0000_0001);

      // MAC1 negative filter, MAC4 with zero offsets
      got.delete();
      push(3'd5, 32'd0, 32'd0);
      push(3'd1, 32'h0000_007F, 32'h0000_00FF);
      push(3'd0, 32'h8080_8080, $urandom);
      drain();
      check("mac1_neg", got[1], 32'hFFFF_FF01);
      check("mac4_zero", got[2], 32'hFFFF_FF01);

      // back-to-back stream
      push(3'd5, 32'd0, 32'd0);
      drain();
      got.delete();
      push(3'd2, 32'd10, 32'd0);
      repeat (3) push(3'd0, 32'd0, 32'h0101_0101);
      push(3'd3, 32'd0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1);
         accb[i] = last_acc;
         rvb[i]  = last_rv;
      end
      drain();
      check("b2b_accepts", 32'(accb), 32'h0000_001F);
      check("b2b_rsp_valid", 32'(rvb), 32'h0000_007C);
      check("b2b_r0", got[0], 32'd0);
      check("b2b_r1", got[1], 32'd522);
      check("b2b_r2", got[2], 32'd1034);
      check("b2b_r3", got[3], 32'd1546);
      check("b2b_r4", got[4], 32'd1546);

      // backpressure: 3 offered, 2 accepted, output held
      got.delete();
      push(3'd0, $urandom, $urandom);
      push(3'd3, 32'd0, 32'd0);
      push(3'd4, 32'd0, 32'd0);
      nacc = 0;
      hold = '0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0);
         if (last_acc) nacc++;
         if (i == 2) begin
            hold = rsp_outputs_0;
            check("bp_first", hold, expq[0]);
         end
         if (i > 2) check("bp_stable", rsp_outputs_0, hold);
      end
      check("bp_accepted", 32'(nacc), 32'd2);
      check("bp_ready_low", 32'(cmd_ready), 32'd0);
      drain();
      check("bp_count", 32'(got.size()), 32'd3);

      // signed overflow
      got.delete();
      push(3'd2, 32'h7FFF_FF00, 32'd0);
      push(3'd0, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
      drain();
`ifdef KWS_MAC_CTRL_SAT_EN
      check("sat", got[1], 32'h7FFF_FFFF);
`else
      check("wrap", got[1], 32'h8001_F904);
`endif

      // reset with a command in flight
      got.delete();
      push(3'd0, 32'd0, 32'h0101_0101);
      cycle(1'b1);
      check("mr_accept", 32'(last_acc), 32'd1);
      reset_n = 1'b0;
      cycle(1'b1);
      reset_n = 1'b1;
      expq.delete();
      m_acc = '0;
      m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1);
         check("mr_no_rsp", 32'(last_rv), 32'd0);
      end
      push(3'd3, 32'd0, 32'd0);
      push(3'd4, 32'd0, 32'd0);
      drain();
      check("mr_acc", got[0], 32'd0);
      check("mr_cnt", got[1], 32'd0);

      // random traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) != 0 && pend.size() < 2) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            if (f == 3'd2 && $urandom_range(0, 1) == 1)
               a = $urandom_range(0, 1) == 1 ? 32'h7FFF_F000 : 32'h8000_0800;
            push(f, a, $urandom);
         end
         cycle($urandom_range(0, 9) < 7);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
